// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : MIPS IF stage - owns the PC, drives icache requests, feeds IF/ID.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic [31:0]      imemload,
    output logic             imemREN,
    output logic [31:0]      imemaddr,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             halt,
    output logic [31:0]      pc_add4,
    output logic [31:0]      instruction,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        REDIR_WAIT = 2'd1,
        HALTED     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en_d, flush_d;
    logic               acc;

    assign imemREN     = ~RST & (state_q != HALTED);
    assign acc         = imemREN & ihit;
    assign imemaddr    = pc_q;
    assign pc_add4     = pc_q + 32'd4;
    assign instruction = imemload;
    assign instr_count = cnt_q;
    assign ifid_en     = ~RST & en_d;
    assign ifid_flush  = ~RST & flush_d;

    // Priority: halt > redirect > pending redirect > stall > normal fetch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        cnt_d     = cnt_q;
        en_d      = 1'b0;
        flush_d   = 1'b0;
        if (state_q != HALTED) begin
            if (halt) begin
                state_d = HALTED;
                flush_d = 1'b1;
            end else if (redirect_valid) begin
                flush_d = 1'b1;
                if (acc) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else begin
                    pend_pc_d = redirect_pc;
                    state_d   = REDIR_WAIT;
                end
            end else if (state_q == REDIR_WAIT) begin
                // Wrong-path word is dropped; the held request must complete first.
                flush_d = 1'b1;
                if (acc) begin
                    pc_d    = pend_pc_q;
                    state_d = FETCH;
                end
            end else if (stall) begin
                en_d = 1'b0;
            end else if (acc) begin
                en_d  = 1'b1;
                pc_d  = pc_q + 32'd4;
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                flush_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= FETCH;
            pc_q      <= PC_INIT;
            pend_pc_q <= 32'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed vector-table bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST, ihit, stall, redirect_valid, halt;
    logic [31:0] imemload, redirect_pc;
    logic        imemREN, ifid_en, ifid_flush;
    logic [31:0] imemaddr, pc_add4, instruction, instr_count;

    logic        ren2, en2, fl2;
    logic [31:0] addr2, add4_2, instr2;
    logic [1:0]  cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .pc_add4(pc_add4), .instruction(instruction), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .instr_count(instr_count)
    );

    // Narrow counter and non-zero reset PC, driven by the same stimulus.
    fetch_unit #(.PC_INIT(32'h0000_1000), .CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(ren2), .imemaddr(addr2), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .pc_add4(add4_2), .instruction(instr2), .ifid_en(en2),
        .ifid_flush(fl2), .instr_count(cnt2)
    );

    typedef struct {
        logic        rst, ihit, stall, rv;
        logic [31:0] rpc;
        logic        ren;
        logic [31:0] addr;
        logic        en, fl;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(logic r, logic h, logic s, logic v, logic [31:0] rp,
                                logic ren, logic [31:0] a, logic e, logic f,
                                logic [31:0] c);
        vec_t t;
        t.rst = r; t.ihit = h; t.stall = s; t.rv = v; t.rpc = rp;
        t.ren = ren; t.addr = a; t.en = e; t.fl = f; t.cnt = c;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic h, input logic s, input logic v,
                         input logic [31:0] rp, input logic hl);
        @(negedge CLK);
        RST = r; ihit = h; stall = s; redirect_valid = v; redirect_pc = rp; halt = hl;
        imemload = $urandom;
        #1;
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'd0; halt = 1'b0; imemload = 32'd0;
        repeat (2) @(posedge CLK);

        //              rst ihit stl rv rpc         ren addr        en fl cnt
        tbl[0]  = mk(1, 1, 0, 0, 32'h0,     0, 32'h0,    0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 32'h0,     1, 32'h0,    1, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 32'h0,     1, 32'h4,    1, 0, 1);
        tbl[3]  = mk(0, 1, 0, 0, 32'h0,     1, 32'h8,    1, 0, 2);
        tbl[4]  = mk(0, 1, 0, 1, 32'h40,    1, 32'hC,    0, 1, 3);
        tbl[5]  = mk(0, 0, 0, 0, 32'h0,     1, 32'h40,   0, 1, 3);
        tbl[6]  = mk(0, 0, 0, 0, 32'h0,     1, 32'h40,   0, 1, 3);
        tbl[7]  = mk(0, 0, 0, 0, 32'h0,     1, 32'h40,   0, 1, 3);
        tbl[8]  = mk(0, 0, 0, 0, 32'h0,     1, 32'h40,   0, 1, 3);
        tbl[9]  = mk(0, 0, 0, 0, 32'h0,     1, 32'h40,   0, 1, 3);
        tbl[10] = mk(0, 1, 0, 0, 32'h0,     1, 32'h40,   1, 0, 3);
        tbl[11] = mk(0, 1, 0, 1, 32'h10,    1, 32'h44,   0, 1, 4);
        tbl[12] = mk(0, 1, 1, 0, 32'h0,     1, 32'h10,   0, 0, 4);
        tbl[13] = mk(0, 1, 1, 0, 32'h0,     1, 32'h10,   0, 0, 4);
        tbl[14] = mk(0, 1, 1, 0, 32'h0,     1, 32'h10,   0, 0, 4);
        tbl[15] = mk(0, 1, 0, 0, 32'h0,     1, 32'h10,   1, 0, 4);
        tbl[16] = mk(0, 1, 0, 1, 32'h20,    1, 32'h14,   0, 1, 5);
        tbl[17] = mk(0, 0, 0, 1, 32'h100,   1, 32'h20,   0, 1, 5);
        tbl[18] = mk(0, 0, 0, 0, 32'h0,     1, 32'h20,   0, 1, 5);
        tbl[19] = mk(0, 0, 0, 1, 32'h200,   1, 32'h20,   0, 1, 5);
        tbl[20] = mk(0, 0, 0, 0, 32'h0,     1, 32'h20,   0, 1, 5);
        tbl[21] = mk(0, 1, 0, 0, 32'h0,     1, 32'h20,   0, 1, 5);
        tbl[22] = mk(0, 1, 0, 0, 32'h0,     1, 32'h200,  1, 0, 5);
        tbl[23] = mk(0, 1, 1, 1, 32'h300,   1, 32'h204,  0, 1, 6);
        tbl[24] = mk(0, 1, 0, 0, 32'h0,     1, 32'h300,  1, 0, 6);
        tbl[25] = mk(0, 0, 0, 1, 32'h500,   1, 32'h304,  0, 1, 7);
        tbl[26] = mk(0, 1, 0, 1, 32'h600,   1, 32'h304,  0, 1, 7);
        tbl[27] = mk(0, 1, 0, 0, 32'h0,     1, 32'h600,  1, 0, 7);
        tbl[28] = mk(0, 0, 1, 0, 32'h0,     1, 32'h604,  0, 0, 8);

        for (int i = 0; i < 29; i++) begin
            drive(tbl[i].rst, tbl[i].ihit, tbl[i].stall, tbl[i].rv, tbl[i].rpc, 1'b0);
            chk($sformatf("v%0d_ren", i),   {31'd0, imemREN},    {31'd0, tbl[i].ren});
            chk($sformatf("v%0d_addr", i),  imemaddr,            tbl[i].addr);
            chk($sformatf("v%0d_add4", i),  pc_add4,             tbl[i].addr + 32'd4);
            chk($sformatf("v%0d_en", i),    {31'd0, ifid_en},    {31'd0, tbl[i].en});
            chk($sformatf("v%0d_flush", i), {31'd0, ifid_flush}, {31'd0, tbl[i].fl});
            chk($sformatf("v%0d_cnt", i),   instr_count,         tbl[i].cnt);
            chk($sformatf("v%0d_instr", i), instruction,         imemload);
        end

        // PC wrap at the top of the address space.
        drive(0, 1, 0, 1, 32'hFFFF_FFFC, 0);
        chk("wrap_redir_fl", {31'd0, ifid_flush}, 32'd1);
        drive(0, 1, 0, 0, 32'h0, 0);
        chk("wrap_addr",  imemaddr,    32'hFFFF_FFFC);
        chk("wrap_add4",  pc_add4,     32'h0);
        chk("wrap_en",    {31'd0, ifid_en}, 32'd1);
        chk("wrap_cnt2",  {30'd0, cnt2}, 32'd0);
        drive(0, 0, 0, 0, 32'h0, 1);
        chk("wrap_pc",    imemaddr,    32'h0);
        chk("wrap_cnt",   instr_count, 32'd9);
        chk("wrap_cnt2b", {30'd0, cnt2}, 32'd1);
        chk("halt_fl",    {31'd0, ifid_flush}, 32'd1);
        chk("halt_en",    {31'd0, ifid_en}, 32'd0);
        chk("halt_ren0",  {31'd0, imemREN}, 32'd1);

        // HALTED ignores everything but reset.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, k[0], 1, 32'h900, 0);
            chk($sformatf("hlt%0d_ren", k),  {31'd0, imemREN},    32'd0);
            chk($sformatf("hlt%0d_en", k),   {31'd0, ifid_en},    32'd0);
            chk($sformatf("hlt%0d_fl", k),   {31'd0, ifid_flush}, 32'd0);
            chk($sformatf("hlt%0d_addr", k), imemaddr,            32'h0);
            chk($sformatf("hlt%0d_cnt", k),  instr_count,         32'd9);
        end

        drive(1, 1, 0, 1, 32'h900, 0);
        chk("rst_ren", {31'd0, imemREN}, 32'd0);
        drive(0, 1, 0, 0, 32'h0, 0);
        chk("rst_pc",   imemaddr,    32'h0);
        chk("rst_pc2",  addr2,       32'h0000_1000);
        chk("rst_cnt",  instr_count, 32'd0);
        chk("rst_en",   {31'd0, ifid_en}, 32'd1);

        // Reset while a redirect is pending discards it.
        drive(0, 0, 0, 1, 32'h700, 0);
        chk("pend_fl", {31'd0, ifid_flush}, 32'd1);
        drive(1, 0, 0, 0, 32'h0, 0);
        chk("pend_rst_fl", {31'd0, ifid_flush}, 32'd0);
        drive(0, 1, 0, 0, 32'h0, 0);
        chk("pend_addr", imemaddr, 32'h0);
        chk("pend_en",   {31'd0, ifid_en}, 32'd1);
        chk("pend_fl2",  {31'd0, ifid_flush}, 32'd0);
        drive(0, 1, 0, 0, 32'h0, 0);
        chk("pend_next", imemaddr, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the pipelined MIPS core. It sits directly upstream of the IF/ID pipeline register and directly below the instruction cache. It owns the PC and issues read requests to the icache, holding each request until ihit. It produces the pc_add4 and instruction values that IF/ID captures, together with that register's write-enable and flush controls, and it absorbs stalls, redirects (branch or jump targets from later stages) and halt.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.
CNT_W, 32, width of the accepted-instruction counter.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  synchronous active-high reset.
ihit  input  1  icache has returned data for the current imemaddr.
imemload  input  32  instruction data from the icache; valid only when ihit=1.
imemREN  output  1  icache read request.
imemaddr  output  32  icache read address; always equals the PC register.
stall  input  1  hazard hold from decode; IF/ID must not advance.
redirect_valid  input  1  a later stage resolved a taken branch or jump.
redirect_pc  input  32  target PC, sampled when redirect_valid=1.
halt  input  1  halt detected downstream; fetch stops permanently until RST.
pc_add4  output  32  PC+4, to the IF/ID pc_add4_in port.
instruction  output  32  the value of imemload, to the IF/ID instruction_in port.
ifid_en  output  1  IF/ID write-enable.
ifid_flush  output  1  IF/ID loads a bubble (NOP, pc_add4=0).
instr_count  output  CNT_W  number of instructions accepted into IF/ID.

Behaviour:
- Reset: synchronous, active-high, single clock CLK. While RST=1 at a rising edge the block loads:
  - pc=PC_INIT, state=FETCH, pend_pc=0, instr_count=0.
  - While RST=1, imemREN=0, ifid_en=0 and ifid_flush=0 are forced combinationally.
  - Asserting RST in any state (including a pending redirect) discards all in-flight work.
- States: FETCH, REDIR_WAIT, HALTED.
  - imemREN=1 in FETCH and REDIR_WAIT.
  - imemREN=0 in HALTED.
- Address stability: imemaddr=pc and is combinational from the register. pc never changes while imemREN=1 and ihit=0. A request, once issued, is held until ihit.
- Definitions: acc = imemREN & ihit. pc_add4 = pc + 32'd4 (mod 2^32; 32'hFFFF_FFFC wraps to 0). instruction = imemload (combinational).
- Priority per cycle: RST > halt > redirect > pending redirect > stall > normal.
- halt=1 (any state except reset):
  - Next state is HALTED and pc holds.
  - ifid_flush=1 that cycle; ifid_en=0.
  - HALTED is terminal; only RST exits.
  - In HALTED: ifid_en=0, ifid_flush=0, and stall, redirect_valid and ihit are ignored.
- redirect_valid=1 and acc=1:
  - pc <= redirect_pc; ifid_flush=1; ifid_en=0; the fetched word is dropped.
  - Next state is FETCH.
  - Applies in FETCH or REDIR_WAIT; redirect_pc overrides any pend_pc.
- redirect_valid=1 and acc=0:
  - pend_pc <= redirect_pc; next state is REDIR_WAIT; pc holds (address stability).
  - ifid_flush=1 that cycle.
  - A later redirect in REDIR_WAIT overwrites pend_pc (the latest one wins).
- REDIR_WAIT, no new redirect:
  - ifid_en=0 and ifid_flush=1 every cycle (the wrong-path word must never enter IF/ID).
  - On acc: pc <= pend_pc, next state is FETCH, and the returned word is discarded.
- FETCH, no redirect, stall=1: pc holds, ifid_en=0, ifid_flush=0. The IF/ID contents are held. imemREN stays 1, so the word is re-fetched after the stall.
- FETCH, no redirect, stall=0:
  - On acc: ifid_en=1, pc <= pc+4, instr_count++.
  - If acc=0: ifid_en=0 and ifid_flush=1 (a bubble is inserted while the miss is outstanding).
- instr_count wraps at 2^CNT_W−1 → 0 and increments only when ifid_en=1.
- ifid_en and ifid_flush are never both 1.
- Latency: an ihit in cycle N is written into IF/ID at the edge ending cycle N. pc advances at that same edge.

Test Plan:
- Reset and straight-line fetch: RST pulse, ihit held 1 → imemaddr sequence 0x0, 0x4, 0x8; ifid_en=1 each cycle; instr_count=3 after 3 cycles; imemREN=0 during RST.
- Miss hold: ihit=0 for 5 cycles at pc=0x40, then ihit=1 → imemaddr stays at 0x40 throughout; ifid_flush=1 for 5 cycles; then ifid_en=1; pc becomes 0x44.
- Stall: stall=1 for 3 cycles with ihit=1 at pc=0x10 → pc stays 0x10; ifid_en=0 and ifid_flush=0; instr_count unchanged; after release, 0x10 is accepted.
- Redirect during a miss: pc=0x20, ihit=0, redirect_valid pulse with 0x100, then a second redirect 0x200 two cycles later, then ihit → imemaddr holds 0x20 until ihit; word discarded; next imemaddr=0x200; no ifid_en during the wait.
- Simultaneous events: redirect_valid=1 (0x300) together with stall=1 and ihit=1 → pc=0x300, ifid_flush=1, ifid_en=0; the redirect wins over stall.
- Halt and wrap: pc=0xFFFF_FFFC with ihit → pc_add4=0x0 and pc wraps to 0; then halt=1 → imemREN=0 from the next cycle; HALTED ignores redirect and ihit until RST, and RST returns pc to PC_INIT.
